instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch initiator for the MIPS-style pipeline. Owns the PC and drives
//  the combinational instruction memory's address (Dir_Instru) and active-low
//  enable (ReadMem). Captures the returned word (Dato_Instru) into the IF/ID
//  register. Supports stall, jump/branch redirect with flush, and a halting
//  fault on out-of-map fetch or misaligned target.
// PARAMETERS
//  RESET_PC  32'h00400000  first fetch address after reset
//  NOP_WORD  32'h38000000  word loaded into IF/ID on reset/flush/fault
//  ERR_WORD  32'hFFFFFFFF  word memory returns for unmapped addresses
// PORTS
//  clk             in   1   system clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  stall           in   1   hold PC and IF/ID this cycle (hazard unit)
//  redirect_valid  in   1   jump/branch taken; load redirect_addr
//  redirect_addr   in   32  target PC
//  ReadMem         out  1   memory enable, active low (0 = read)
//  Dir_Instru      out  32  fetch address to memory (= pc)
//  Dato_Instru     in   32  instruction word, combinational response, same cycle
//  if_instr        out  32  IF/ID instruction register
//  if_pc           out  32  PC of if_instr
//  if_pc4          out  32  if_pc + 4
//  if_valid        out  1   if_instr is a real fetched instruction
//  fault           out  1   sticky; fetch halted
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, pc=RESET_PC, if_instr=NOP_WORD, if_pc=0,
//   if_pc4=4, if_valid=0, fault=0, ReadMem=1. Takes effect mid-cycle, no edge needed.
//  Dir_Instru = pc always. ReadMem = 0 only in RUN, 1 in IDLE and HALT.
//  States: IDLE -> RUN unconditionally on first edge after rst_n high (1 cycle).
//   RUN -> HALT on fault condition. HALT exits only via reset.
//  RUN, per rising edge, priority high to low:
//   1 redirect_valid, redirect_addr[1:0]!=0: HALT, fault=1, if_instr=NOP, if_valid=0.
//   2 redirect_valid: pc<=redirect_addr; if_instr<=NOP_WORD; if_valid<=0
//     (flush the delay-slot fetch); overrides stall.
//   3 stall: pc, if_instr, if_pc, if_pc4, if_valid all hold.
//   4 Dato_Instru==ERR_WORD: HALT, fault<=1, if_instr<=NOP_WORD, if_valid<=0,
//     pc holds at faulting address.
//   5 else: if_instr<=Dato_Instru, if_pc<=pc, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
//  Latency: word at address A appears on if_instr one edge after Dir_Instru=A
//   with no stall; throughput one instruction per cycle.
//  Arithmetic: 32-bit modulo; pc 32'hFFFFFFFC + 4 wraps to 0, no flag.
//  Stall during IDLE ignored; redirect during IDLE ignored.
//  HALT: all IF/ID outputs hold NOP/invalid, pc frozen, inputs ignored.
// TESTING
//  T1 reset release: edge1 ReadMem=1, Dir=00400000; edge2 if_instr=38000000,
//     if_pc=00400000; edge3 if_instr=8D710001, Dir=00400008.
//  T2 stall 3 cycles with Dir=00400008: if_instr stays 8D710001, Dir stays
//     00400008, ReadMem=0; release -> if_instr=8D720002.
//  T3 redirect_valid+stall, addr=00400080: next edge Dir=00400080, if_instr=
//     38000000, if_valid=0; following edge if_instr=8232A820.
//  T4 run to Dir=00400088 (memory returns FFFFFFFF): fault=1, ReadMem=1,
//     if_valid=0, Dir stays 00400088 for 10+ cycles.
//  T5 redirect_addr=00400082: fault=1 next edge, if_instr=38000000.
//  T6 rst_n low mid-cycle while running at 00400040: outputs reach reset values
//     before next edge; restart from 00400000 as in T1.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and loads the IF/ID register. Handles stall, redirect with flush of
// the in-flight fetch, and a sticky halting fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h3800_0000,
  parameter logic [31:0] ERR_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        ReadMem,
  output logic [31:0] Dir_Instru,
  input  logic [31:0] Dato_Instru,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  // State and IF/ID register; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h4;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: IDLE spends one cycle, RUN applies redirect > stall > fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid && (redirect_addr[1:0] != 2'b00)) begin
          // misaligned target: stop fetching, pc stays put
          state_d = HALT;
          fault_d = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          // the word fetched this cycle is the wrong path; drop it
          pc_d    = redirect_addr;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (Dato_Instru == ERR_WORD) begin
            state_d = HALT;
            fault_d = 1'b1;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d = Dato_Instru;
            ipc_d   = pc_q;
            ipc4_d  = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  assign ReadMem    = (state_q != RUN);
  assign Dir_Instru = pc_q;
  assign if_instr   = instr_q;
  assign if_pc      = ipc_q;
  assign if_pc4     = ipc4_q;
  assign if_valid   = valid_q;
  assign fault      = fault_q;

endmodule
